// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier pipe: rounding modes, flag bit positions
// and the packed IEEE-754 result layout.
package mul_pkg;

  localparam int SIGN_W = 1;
  localparam int EXPO_W = 8;
  localparam int MANT_W = 23;
  localparam int RES_W  = SIGN_W + EXPO_W + MANT_W;

  typedef enum logic [1:0] {
    RTZ = 2'b00,
    RDN = 2'b01,
    RUP = 2'b10,
    RNE = 2'b11
  } rnd_mode_e;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXPO_W-1:0] expo;
    logic [MANT_W-1:0] mant;
  } fp_res_t;

endpackage

// File: rtl/mul_pack_skid.sv
// Generic two-entry valid/ready skid buffer (main register plus one skid register).
// Latency: 1 cycle from upstream transfer to dn_vld when empty.
// Backpressure: up_rdy = !skid full, registered only; skid drains into main as main empties.
module mul_pack_skid #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_dat,
  output logic         dn_vld,
  input  logic         dn_rdy,
  output logic [W-1:0] dn_dat
);

  logic         main_vld;
  logic         skid_vld;
  logic [W-1:0] main_dat;
  logic [W-1:0] skid_dat;
  logic         main_free;

  assign up_rdy    = !skid_vld;
  assign dn_vld    = main_vld;
  assign dn_dat    = main_dat;
  assign main_free = !main_vld || dn_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (main_free) begin
      // A full skid implies up_rdy is low, so no new word competes for main here.
      if (skid_vld) begin
        main_dat <= skid_dat;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (up_vld) begin
        main_dat <= up_dat;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (up_vld && !skid_vld) begin
      skid_dat <= up_dat;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/mul_pack.sv
// Multiplier output stage: resolves specials/overflow/underflow, packs the result, keeps sticky flags.
// Latency: 1 cycle from input transfer to out_valid when empty; throughput 1/cycle.
// Backpressure: one-entry skid; in_ready depends only on registered state.
module mul_pack
  import mul_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             sign_1,
  input  logic [EXPO_W+1:0]                expo_3,
  input  logic [MANT_W-1:0]                mant_3,
  input  logic                             inexact_rnd,
  input  logic [1:0]                       rnd,
  input  logic                             spec_nan,
  input  logic                             spec_nv,
  input  logic                             spec_inf,
  input  logic                             spec_zero,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0] result,
  output logic [3:0]                       flags,
  output logic [3:0]                       fflags,
  input  logic                             fflags_clr
);

  localparam int EW = EXPO_W + 2;
  localparam int PW = SIGN_W + EXPO_W + MANT_W + 4;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXPO_W) - 1);

  logic signed [EW-1:0] expo_s;
  rnd_mode_e            mode;
  logic                 to_inf;
  logic [SIGN_W-1:0]    r_sign;
  logic [EXPO_W-1:0]    r_expo;
  logic [MANT_W-1:0]    r_mant;
  logic [3:0]           r_flags;
  logic [PW-1:0]        out_dat;

  assign expo_s = expo_3;
  assign mode   = rnd_mode_e'(rnd);
  assign to_inf = (mode == RNE) || (mode == RUP && !sign_1) || (mode == RDN && sign_1);

  always_comb begin
    r_sign  = SIGN_W'(sign_1);
    r_expo  = expo_3[EXPO_W-1:0];
    r_mant  = mant_3;
    r_flags = '0;
    if (spec_nan) begin
      r_sign           = '0;
      r_expo           = '1;
      r_mant           = '0;
      r_mant[MANT_W-1] = 1'b1;
      r_flags[FLAG_NV] = spec_nv;
    end else if (spec_inf) begin
      r_expo = '1;
      r_mant = '0;
    end else if (spec_zero) begin
      r_expo = '0;
      r_mant = '0;
    end else if (expo_s >= EMAX) begin
      r_flags[FLAG_OF] = 1'b1;
      r_flags[FLAG_NX] = 1'b1;
      if (to_inf) begin
        r_expo = '1;
        r_mant = '0;
      end else begin
        // Largest finite magnitude: EMAX-1 with an all-ones mantissa.
        r_expo    = '1;
        r_expo[0] = 1'b0;
        r_mant    = '1;
      end
    end else if (expo_s[EW-1]) begin
      r_expo           = '0;
      r_mant           = '0;
      r_flags[FLAG_UF] = 1'b1;
      r_flags[FLAG_NX] = 1'b1;
    end else begin
      r_flags[FLAG_NX] = inexact_rnd;
      r_flags[FLAG_UF] = inexact_rnd && (expo_s == '0);
    end
  end

  mul_pack_skid #(.W(PW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .up_vld (in_valid),
    .up_rdy (in_ready),
    .up_dat ({r_sign, r_expo, r_mant, r_flags}),
    .dn_vld (out_valid),
    .dn_rdy (out_ready),
    .dn_dat (out_dat)
  );

  assign result = out_dat[PW-1:4];
  assign flags  = out_dat[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags <= '0;
    end else if (fflags_clr) begin
      fflags <= '0;
    end else if (out_valid && out_ready) begin
      fflags <= fflags | flags;
    end
  end

endmodule

// File: tb/tb_mul_pack.sv
// Self-checking bench for mul_pack (FP32): directed vectors, backpressure,
// randomized traffic against a queue-based reference model, and mid-run reset.
module tb_mul_pack;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_1 = 1'b0;
  logic [9:0]  expo_3 = '0;
  logic [22:0] mant_3 = '0;
  logic        inexact_rnd = 1'b0;
  logic [1:0]  rnd = 2'b11;
  logic        spec_nan = 1'b0;
  logic        spec_nv = 1'b0;
  logic        spec_inf = 1'b0;
  logic        spec_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [3:0]  fflags;
  logic        fflags_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Current stimulus kept as plain integers for the reference model.
  bit          st_s, st_inex, st_nan, st_nv, st_inf, st_zero;
  int          st_e;
  logic [22:0] st_m;
  logic [1:0]  st_r;

  always #5 clk = ~clk;

  mul_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_1(sign_1), .expo_3(expo_3), .mant_3(mant_3), .inexact_rnd(inexact_rnd),
    .rnd(rnd), .spec_nan(spec_nan), .spec_nv(spec_nv), .spec_inf(spec_inf),
    .spec_zero(spec_zero), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .fflags(fflags), .fflags_clr(fflags_clr)
  );

  // Returns {result, flags {NV,OF,UF,NX}} for the current stimulus.
  function automatic logic [35:0] ref_pack();
    fp_res_t    res;
    logic [3:0] f;
    bit         inf_rnd;
    res = '0;
    f   = 4'b0000;
    res.sign = st_s;
    inf_rnd = (st_r == 2'b11) || (st_r == 2'b10 && !st_s) || (st_r == 2'b01 && st_s);
    if (st_nan) begin
      res = 32'h7FC00000;
      f   = st_nv ? 4'b1000 : 4'b0000;
    end else if (st_inf) begin
      res.expo = 8'hFF;
    end else if (st_zero) begin
      res.expo = 8'h00;
    end else if (st_e >= 255) begin
      f = 4'b0101;
      if (inf_rnd) res.expo = 8'hFF;
      else begin
        res.expo = 8'hFE;
        res.mant = 23'h7FFFFF;
      end
    end else if (st_e < 0) begin
      f = 4'b0011;
    end else begin
      res.expo = 8'(st_e);
      res.mant = st_m;
      f = {2'b00, st_inex && st_e == 0, st_inex};
    end
    return {res, f};
  endfunction

  task automatic set_in(input bit s, input int e, input logic [22:0] m, input bit inex,
                        input logic [1:0] r, input bit nan, input bit nv, input bit inf,
                        input bit zero);
    st_s = s; st_e = e; st_m = m; st_inex = inex; st_r = r;
    st_nan = nan; st_nv = nv; st_inf = inf; st_zero = zero;
    sign_1 = s; expo_3 = e[9:0]; mant_3 = m; inexact_rnd = inex; rnd = r;
    spec_nan = nan; spec_nv = nv; spec_inf = inf; spec_zero = zero;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    checks++; if (fflags !== 4'h0) begin errors++; $display("FAIL reset_fflags: got %b want 0000", fflags); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] er;
    logic [3:0]  ef;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:  begin set_in(0, 127, 23'h0, 0, 2'b11, 0, 0, 0, 0);   er = 32'h3F800000; ef = 4'b0000; end
        1:  begin set_in(1, 255, 23'h0, 0, 2'b00, 0, 0, 0, 0);   er = 32'hFF7FFFFF; ef = 4'b0101; end
        2:  begin set_in(1, 255, 23'h0, 0, 2'b01, 0, 0, 0, 0);   er = 32'hFF800000; ef = 4'b0101; end
        3:  begin set_in(1, 5, 23'h7B, 1, 2'b10, 1, 1, 1, 1);    er = 32'h7FC00000; ef = 4'b1000; end
        4:  begin set_in(0, 0, 23'h1, 1, 2'b11, 0, 0, 0, 0);     er = 32'h00000001; ef = 4'b0011; end
        5:  begin set_in(0, -3, 23'h0, 0, 2'b11, 0, 0, 0, 0);    er = 32'h00000000; ef = 4'b0011; end
        6:  begin set_in(1, 40, 23'h55, 1, 2'b11, 0, 0, 1, 0);   er = 32'hFF800000; ef = 4'b0000; end
        7:  begin set_in(1, 100, 23'h55, 1, 2'b11, 0, 0, 0, 1);  er = 32'h80000000; ef = 4'b0000; end
        8:  begin set_in(1, 300, 23'h12, 0, 2'b10, 0, 0, 0, 0);  er = 32'hFF7FFFFF; ef = 4'b0101; end
        9:  begin set_in(0, 200, 23'h12, 0, 2'b11, 1, 0, 0, 0);  er = 32'h7FC00000; ef = 4'b0000; end
        10: begin set_in(0, 254, 23'h7FFFFF, 1, 2'b00, 0, 0, 0, 0); er = 32'h7F7FFFFF; ef = 4'b0001; end
        default: begin set_in(0, 0, 23'h5, 0, 2'b11, 0, 0, 0, 0); er = 32'h00000005; ef = 4'b0000; end
      endcase
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid: got %b want 1", i, out_valid); end
      checks++; if (result !== er) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, result, er); end
      checks++; if (flags !== ef) begin errors++; $display("FAIL dir%0d_flags: got %b want %b", i, flags, ef); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (fflags !== 4'b1111) begin errors++; $display("FAIL dir_fflags: got %b want 1111", fflags); end
  endtask

  task automatic test_backpressure();
    logic [35:0] a, b, c;
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    checks++; if (fflags !== 4'b0000) begin errors++; $display("FAIL bp_clear: got %b want 0000", fflags); end
    out_ready = 1'b0;
    set_in(0, 100, 23'h123, 1, 2'b11, 0, 0, 0, 0); a = ref_pack();
    @(posedge clk); #1;
    checks++; if ({result, flags} !== a || out_valid !== 1'b1) begin errors++; $display("FAIL bp_a_main: got %h v=%b want %h", {result, flags}, out_valid, a); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    set_in(1, -7, 23'h44, 0, 2'b01, 0, 0, 0, 0); b = ref_pack();
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    checks++; if ({result, flags} !== a) begin errors++; $display("FAIL bp_a_hold1: got %h want %h", {result, flags}, a); end
    set_in(1, 260, 23'h0, 0, 2'b00, 0, 0, 0, 0); c = ref_pack();
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full2: got %b want 0", in_ready); end
    checks++; if ({result, flags} !== a) begin errors++; $display("FAIL bp_a_hold2: got %h want %h", {result, flags}, a); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({result, flags} !== b || out_valid !== 1'b1) begin errors++; $display("FAIL bp_b_out: got %h want %h", {result, flags}, b); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_drain: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({result, flags} !== c || out_valid !== 1'b1) begin errors++; $display("FAIL bp_c_out: got %h want %h", {result, flags}, c); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    checks++; if (fflags !== (a[3:0] | b[3:0] | c[3:0])) begin errors++; $display("FAIL bp_fflags: got %b want %b", fflags, a[3:0] | b[3:0] | c[3:0]); end
  endtask

  task automatic test_random();
    logic [35:0] q[$];
    logic [3:0]  ff_m;
    bit          oxfer, ixfer;
    int          e;
    in_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fflags_clr = 1'b0;
    ff_m = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if ({result, flags} !== q[0]) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", n, {result, flags}, q[0]); end
      end
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, in_ready, q.size() < 2); end
      checks++; if (fflags !== ff_m) begin errors++; $display("FAIL rnd_fflags@%0d: got %b want %b", n, fflags, ff_m); end
      oxfer = (q.size() != 0) && out_ready;
      ixfer = in_valid && (q.size() < 2);
      if (fflags_clr) ff_m = 4'b0000;
      else if (oxfer) ff_m = ff_m | q[0][3:0];
      if (oxfer) void'(q.pop_front());
      if (ixfer) q.push_back(ref_pack());
      @(posedge clk); #1;
      case ($urandom_range(0, 9))
        0:       e = -int'($urandom_range(1, 40));
        1:       e = 0;
        2:       e = int'($urandom_range(255, 511));
        3:       e = 255;
        4:       e = -512;
        default: e = int'($urandom_range(1, 254));
      endcase
      set_in(1'($urandom), e, 23'($urandom), 1'($urandom), 2'($urandom),
             $urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 15) == 0,
             $urandom_range(0, 15) == 0);
      in_valid   = $urandom_range(0, 3) != 0;
      out_ready  = $urandom_range(0, 2) != 0;
      fflags_clr = $urandom_range(0, 19) == 0;
    end
  endtask

  task automatic test_reset_mid();
    fflags_clr = 1'b0;
    out_ready  = 1'b0;
    set_in(0, 50, 23'h9, 1, 2'b11, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b want 0", in_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    checks++; if (result !== 32'h0 || flags !== 4'h0) begin errors++; $display("FAIL mid_data: got %h/%b want 0/0", result, flags); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
